seq_priority_enc: RTL and testbench

Sequential, parametrised priority encoder. It accepts an input bit vector through a valid/ready handshake and emits the index of every set bit, one index per cycle, in priority order. Each index is presented on an output valid/ready stream. It is the registered, multi-hit generalisation of the lab's combinational any-bit encoder and sits between switch or request registers and downstream consumers such as LED/7-segment drivers or arbiters.

---
 rtl/seq_priority_enc_if.sv | 27 ++
 rtl/seq_priority_enc.sv | 117 +++++++++++
 tb/tb_seq_priority_enc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_priority_enc_if.sv
// rtl/seq_priority_enc_if.sv - load and index-stream bundle for seq_priority_enc
interface seq_priority_enc_if #(
    parameter int OUT_SIZE = 4,
    parameter int IN_SIZE  = 1 << OUT_SIZE
);
    logic [IN_SIZE-1:0]  in;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_SIZE-1:0] out_index;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                out_none;
    logic [OUT_SIZE:0]   count;

    // Vector source and index consumer side
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out_index, out_valid, out_last, out_none, count
    );

    // Encoder side
    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out_index, out_valid, out_last, out_none, count
    );
endinterface

// File: rtl/seq_priority_enc.sv
// rtl/seq_priority_enc.sv - sequential multi-hit priority encoder, one index per beat
module seq_priority_enc #(
    parameter int OUT_SIZE  = 4,
    parameter int IN_SIZE   = 1 << OUT_SIZE,
    parameter int MSB_FIRST = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    seq_priority_enc_if.slave bus
);
    localparam int CW = OUT_SIZE + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state;
    logic [IN_SIZE-1:0]  pending;
    logic [IN_SIZE-1:0]  next_pending;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       beat_cnt;
    logic                none_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [OUT_SIZE-1:0] out_index_q;
    logic                out_last_q;

    // First set bit in scan order; an empty vector reports index 0.
    function automatic logic [OUT_SIZE-1:0] first_set(input logic [IN_SIZE-1:0] v);
        logic [OUT_SIZE-1:0] idx;
        idx = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (MSB_FIRST != 0) begin
                if (v[i]) idx = OUT_SIZE'(i);
            end else begin
                if (v[IN_SIZE-1-i]) idx = OUT_SIZE'(IN_SIZE-1-i);
            end
        end
        return idx;
    endfunction

    function automatic logic at_most_one(input logic [IN_SIZE-1:0] v);
        return (v & (v - IN_SIZE'(1))) == '0;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [IN_SIZE-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < IN_SIZE; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Pending vector with the currently reported bit removed
    always_comb begin
        next_pending = pending & ~(IN_SIZE'(1) << out_index_q);
    end

    // Control FSM; every output is registered so the next index is looked up one beat ahead
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= '0;
            count_q     <= '0;
            beat_cnt    <= '0;
            none_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending     <= bus.in;
                        count_q     <= popcount(bus.in);
                        none_q      <= (bus.in == '0);
                        beat_cnt    <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_index_q <= first_set(bus.in);
                        out_last_q  <= at_most_one(bus.in);
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (out_last_q) begin
                            pending     <= '0;
                            count_q     <= '0;
                            none_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_index_q <= '0;
                            out_last_q  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            pending     <= next_pending;
                            out_index_q <= first_set(next_pending);
                            out_last_q  <= at_most_one(next_pending);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_none  = none_q;
    assign bus.count     = count_q;

    // Beats issued must match the popcount latched at load (an empty vector still issues one beat)
    beat_count_matches: assert property (@(posedge clock) disable iff (!reset_n)
        (state == SCAN && bus.out_ready && out_last_q) |->
        ((none_q ? CW'(0) : beat_cnt + CW'(1)) == count_q));
endmodule

// File: tb/tb_seq_priority_enc.sv
// tb/tb_seq_priority_enc.sv - scoreboard bench for seq_priority_enc (LSB-first 16 bit, MSB-first 10 bit)
module tb_seq_priority_enc;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    seq_priority_enc_if #(.OUT_SIZE(4), .IN_SIZE(16)) bus_a ();
    seq_priority_enc_if #(.OUT_SIZE(4), .IN_SIZE(10)) bus_b ();

    seq_priority_enc #(.OUT_SIZE(4), .IN_SIZE(16), .MSB_FIRST(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
    seq_priority_enc #(.OUT_SIZE(4), .IN_SIZE(10), .MSB_FIRST(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    typedef struct { int idx; int last; int none; int cnt; } beat_t;
    typedef struct { logic [15:0] vec; int beats; int cnt; } vec_a_t;
    typedef struct { logic [9:0]  vec; int beats; int cnt; } vec_b_t;

    beat_t  q_a[$];
    beat_t  q_b[$];
    beat_t  ea, eb;
    vec_a_t tab_a[7];
    vec_b_t tab_b[4];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected beats, lowest index first
    task automatic push_a(input logic [15:0] v);
        int n = 0;
        int seen = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        if (v == 16'h0) q_a.push_back('{0, 1, 1, 0});
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                seen++;
                q_a.push_back('{i, int'(seen == n), 0, n});
            end
        end
    endtask

    // Expected beats, highest index first
    task automatic push_b(input logic [9:0] v);
        int n = 0;
        int seen = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        if (v == 10'h0) q_b.push_back('{0, 1, 1, 0});
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) begin
                seen++;
                q_b.push_back('{i, int'(seen == n), 0, n});
            end
        end
    endtask

    // Scoreboard: a beat seen valid&ready mid-cycle transfers at the next rising edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (q_a.size() == 0) check("a_beat_expected", 32'(q_a.size()), 1);
                else begin
                    ea = q_a.pop_front();
                    check("a_index", 32'(bus_a.out_index), ea.idx);
                    check("a_last",  32'(bus_a.out_last),  ea.last);
                    check("a_none",  32'(bus_a.out_none),  ea.none);
                    check("a_count", 32'(bus_a.count),     ea.cnt);
                end
            end else if (!bus_a.out_valid) begin
                check("a_idle_index", 32'(bus_a.out_index), 0);
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                if (q_b.size() == 0) check("b_beat_expected", 32'(q_b.size()), 1);
                else begin
                    eb = q_b.pop_front();
                    check("b_index", 32'(bus_b.out_index), eb.idx);
                    check("b_last",  32'(bus_b.out_last),  eb.last);
                    check("b_none",  32'(bus_b.out_none),  eb.none);
                    check("b_count", 32'(bus_b.count),     eb.cnt);
                end
            end
        end
    end

    // Called just after a rising edge with in_ready=1; returns just after the edge where in_ready rises again
    task automatic load_a(input logic [15:0] v, input int exp_beats, input int exp_cnt);
        int n = 0;
        check("a_ready_before_load", 32'(bus_a.in_ready), 1);
        bus_a.in = v;
        bus_a.in_valid = 1'b1;
        push_a(v);
        @(posedge clock); #1;
        bus_a.in_valid = 1'b0;
        check("a_valid_after_load", 32'(bus_a.out_valid), 1);
        check("a_count_after_load", 32'(bus_a.count), exp_cnt);
        while (!bus_a.in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("a_scan_cycles", n, exp_beats);
    endtask

    task automatic load_b(input logic [9:0] v, input int exp_beats, input int exp_cnt);
        int n = 0;
        check("b_ready_before_load", 32'(bus_b.in_ready), 1);
        bus_b.in = v;
        bus_b.in_valid = 1'b1;
        push_b(v);
        @(posedge clock); #1;
        bus_b.in_valid = 1'b0;
        check("b_valid_after_load", 32'(bus_b.out_valid), 1);
        check("b_count_after_load", 32'(bus_b.count), exp_cnt);
        while (!bus_b.in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("b_scan_cycles", n, exp_beats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tab_a[0] = '{16'h8421, 4, 4};
        tab_a[1] = '{16'h0000, 1, 0};
        tab_a[2] = '{16'h0001, 1, 1};
        tab_a[3] = '{16'h8000, 1, 1};
        tab_a[4] = '{16'hFFFF, 16, 16};
        tab_a[5] = '{16'h00F0, 4, 4};
        tab_a[6] = '{16'hA5A5, 8, 8};
        tab_b[0] = '{10'b10_0000_0011, 3, 3};
        tab_b[1] = '{10'b00_0000_0001, 1, 1};
        tab_b[2] = '{10'b00_0000_0000, 1, 0};
        tab_b[3] = '{10'b11_1111_1111, 10, 10};

        bus_a.in = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;

        // Reset takes effect mid-cycle without a clock edge
        #1 reset_n = 1'b0;
        #2;
        check("rst_in_ready",  32'(bus_a.in_ready),  1);
        check("rst_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_out_index", 32'(bus_a.out_index), 0);
        check("rst_out_last",  32'(bus_a.out_last),  0);
        check("rst_out_none",  32'(bus_a.out_none),  0);
        check("rst_count",     32'(bus_a.count),     0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Table of vectors, consumer always ready, back-to-back loads
        for (int i = 0; i < 7; i++) load_a(tab_a[i].vec, tab_a[i].beats, tab_a[i].cnt);

        // Backpressure on the second beat, with in_valid noise during the scan
        check("bp_ready_before_load", 32'(bus_a.in_ready), 1);
        bus_a.in = 16'h8421;
        bus_a.in_valid = 1'b1;
        push_a(16'h8421);
        @(posedge clock); #1;
        bus_a.in_valid = 1'b0;
        @(posedge clock); #1;
        check("bp_second_index", 32'(bus_a.out_index), 5);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("bp_hold_index", 32'(bus_a.out_index), 5);
            check("bp_hold_last",  32'(bus_a.out_last),  0);
            check("bp_hold_valid", 32'(bus_a.out_valid), 1);
            check("bp_hold_count", 32'(bus_a.count),     4);
            check("bp_in_ready",   32'(bus_a.in_ready),  0);
        end
        bus_a.out_ready = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in = '0;
        n = 0;
        while (!bus_a.in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("bp_resume_cycles", n, 3);

        // MSB-first, 10-bit instance
        for (int i = 0; i < 4; i++) load_b(tab_b[i].vec, tab_b[i].beats, tab_b[i].cnt);

        // Reset in the middle of a scan
        bus_a.in = 16'hFFFF;
        bus_a.in_valid = 1'b1;
        push_a(16'hFFFF);
        @(posedge clock); #1;
        bus_a.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("mid_index_before_rst", 32'(bus_a.out_index), 3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus_a.out_valid), 0);
        check("mid_rst_in_ready",  32'(bus_a.in_ready),  1);
        check("mid_rst_out_index", 32'(bus_a.out_index), 0);
        check("mid_rst_count",     32'(bus_a.count),     0);
        check("mid_rst_out_last",  32'(bus_a.out_last),  0);
        check("mid_discarded_beats", 32'(q_a.size()), 13);
        q_a.delete();
        @(posedge clock); #1;
        check("mid_no_beat_in_reset", 32'(bus_a.out_valid), 0);
        reset_n = 1'b1;
        load_a(16'h0002, 1, 1);

        repeat (2) @(posedge clock);
        #1;
        check("a_queue_drained", 32'(q_a.size()), 0);
        check("b_queue_drained", 32'(q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
